// File: rtl/motion_estimator.sv
// motion_estimator
// Full-search block motion estimator. For every 4x4 block of the current
// frame it tries all candidate vectors in -SR..+SR (mvy outer, mvx inner),
// computes the sum of absolute differences against the reference frame and
// writes the best vector (lowest SAD, earliest on ties) to the MV memory.
//
// Ports
//   CLK, reset         rising-edge clock, asynchronous active-high reset
//   start              single-cycle pulse, accepted only in IDLE/DONE
//   width, height      frame size in 4x4 blocks, sampled on accepted start
//   cur_addr/cur_pix   current-frame read port, data one cycle after address
//   ref_addr/ref_pix   reference-frame read port, data one cycle after address
//   mv_we              one-cycle MV write strobe
//   mv_index           block index bx + by*width
//   mvx, mvy           signed best vector, ref pixel = ref(px-mvx, py-mvy)
//   busy               high while a frame is being processed
//   MV_fin             level, high once the last MV of the frame is written
module motion_estimator #(
  parameter int SR = 2,
  parameter int BS = 4
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        width,
  input  logic [7:0]        height,
  output logic [15:0]       cur_addr,
  input  logic [7:0]        cur_pix,
  output logic [15:0]       ref_addr,
  input  logic [7:0]        ref_pix,
  output logic              mv_we,
  output logic [15:0]       mv_index,
  output logic signed [7:0] mvx,
  output logic signed [7:0] mvy,
  output logic              busy,
  output logic              MV_fin
);

  typedef enum logic [2:0] {
    IDLE, BLK_INIT, CAND, ISSUE, DRAIN, CMP, WRITE, DONE
  } state_t;

  localparam logic signed [7:0] SR_POS = 8'(SR);
  localparam logic signed [7:0] SR_NEG = 8'(-SR);
  localparam logic [3:0]        K_LAST = 4'(BS * BS - 1);

  state_t state_q, state_d;
  logic [7:0] width_q, width_d, height_q, height_d;
  logic [7:0] bx_q, bx_d, by_q, by_d;
  logic signed [7:0] candX_q, candX_d, candY_q, candY_d;
  logic signed [7:0] bestX_q, bestX_d, bestY_q, bestY_d;
  logic [12:0] bestSad_q, bestSad_d, sad_q, sad_d;
  logic [3:0]  k_q, k_d;
  logic        pend_q, pend_d;
  logic [15:0] curAddr_q, curAddr_d, refAddr_q, refAddr_d;

  logic signed [15:0] frameW, frameH, refX0, refY0;
  logic        candValid, lastCand;
  logic signed [7:0] nextX, nextY;
  logic [3:0]  kSel;
  logic [16:0] px, py, rowW, rpx, rpy, curFull, refFull;
  logic        unusedCurTop, unusedRefTop;
  logic [7:0]  absDiff;

  // A candidate is usable only if the whole shifted 4x4 block lies inside
  // the reference frame; checking the top-left corner and the +3 corner
  // covers all 16 pixels.
  always_comb begin
    frameW    = $signed({6'd0, width_q, 2'b00});
    frameH    = $signed({6'd0, height_q, 2'b00});
    refX0     = $signed({6'd0, bx_q, 2'b00}) - {{8{candX_q[7]}}, candX_q};
    refY0     = $signed({6'd0, by_q, 2'b00}) - {{8{candY_q[7]}}, candY_q};
    candValid = (refX0 >= 16'sd0) && (refX0 + 16'sd3 < frameW) &&
                (refY0 >= 16'sd0) && (refY0 + 16'sd3 < frameH);
    lastCand  = (candX_q == SR_POS) && (candY_q == SR_POS);
    nextX     = (candX_q == SR_POS) ? SR_NEG : candX_q + 8'sd1;
    nextY     = (candX_q == SR_POS) ? candY_q + 8'sd1 : candY_q;
  end

  // Address of the pixel to be fetched next: pixel 0 when leaving CAND,
  // pixel k+1 while issuing. Arithmetic is 17 bits wide; only the low 16
  // bits reach the ports.
  always_comb begin
    kSel         = (state_q == ISSUE) ? k_q + 4'd1 : 4'd0;
    px           = {7'd0, bx_q, 2'b00} + {15'd0, kSel[1:0]};
    py           = {7'd0, by_q, 2'b00} + {15'd0, kSel[3:2]};
    rowW         = {7'd0, width_q, 2'b00};
    rpx          = px - {{9{candX_q[7]}}, candX_q};
    rpy          = py - {{9{candY_q[7]}}, candY_q};
    curFull      = px + py * rowW;
    refFull      = rpx + rpy * rowW;
    unusedCurTop = curFull[16];
    unusedRefTop = refFull[16];
    absDiff      = (cur_pix >= ref_pix) ? cur_pix - ref_pix : ref_pix - cur_pix;
  end

  // Next-state and datapath updates. Read data trails the address by one
  // cycle, so pend_q marks cycles in which a returned pair must be summed;
  // DRAIN exists only to absorb the sixteenth return.
  always_comb begin
    state_d   = state_q;
    width_d   = width_q;
    height_d  = height_q;
    bx_d      = bx_q;
    by_d      = by_q;
    candX_d   = candX_q;
    candY_d   = candY_q;
    bestX_d   = bestX_q;
    bestY_d   = bestY_q;
    bestSad_d = bestSad_q;
    k_d       = k_q;
    curAddr_d = curAddr_q;
    refAddr_d = refAddr_q;
    pend_d    = (state_q == ISSUE);
    sad_d     = pend_q ? sad_q + {5'd0, absDiff} : sad_q;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          width_d  = width;
          height_d = height;
          bx_d     = 8'd0;
          by_d     = 8'd0;
          state_d  = BLK_INIT;
        end
      end
      BLK_INIT: begin
        if (width_q == 8'd0 || height_q == 8'd0) begin
          state_d = DONE;
        end else begin
          bestSad_d = 13'h1FFF;
          bestX_d   = 8'sd0;
          bestY_d   = 8'sd0;
          candX_d   = SR_NEG;
          candY_d   = SR_NEG;
          state_d   = CAND;
        end
      end
      CAND: begin
        if (candValid) begin
          k_d       = 4'd0;
          sad_d     = 13'd0;
          curAddr_d = curFull[15:0];
          refAddr_d = refFull[15:0];
          state_d   = ISSUE;
        end else if (lastCand) begin
          state_d = WRITE;
        end else begin
          candX_d = nextX;
          candY_d = nextY;
        end
      end
      ISSUE: begin
        if (k_q == K_LAST) begin
          state_d = DRAIN;
        end else begin
          k_d       = k_q + 4'd1;
          curAddr_d = curFull[15:0];
          refAddr_d = refFull[15:0];
        end
      end
      DRAIN: begin
        state_d = CMP;
      end
      CMP: begin
        // Strict compare: an equal SAD never displaces an earlier candidate.
        if (sad_q < bestSad_q) begin
          bestSad_d = sad_q;
          bestX_d   = candX_q;
          bestY_d   = candY_q;
        end
        if (lastCand) begin
          state_d = WRITE;
        end else begin
          candX_d = nextX;
          candY_d = nextY;
          state_d = CAND;
        end
      end
      WRITE: begin
        if (bx_q == width_q - 8'd1) begin
          bx_d = 8'd0;
          if (by_q == height_q - 8'd1) begin
            state_d = DONE;
          end else begin
            by_d    = by_q + 8'd1;
            state_d = BLK_INIT;
          end
        end else begin
          bx_d    = bx_q + 8'd1;
          state_d = BLK_INIT;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any frame in progress.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      width_q   <= 8'd0;
      height_q  <= 8'd0;
      bx_q      <= 8'd0;
      by_q      <= 8'd0;
      candX_q   <= 8'sd0;
      candY_q   <= 8'sd0;
      bestX_q   <= 8'sd0;
      bestY_q   <= 8'sd0;
      bestSad_q <= 13'd0;
      sad_q     <= 13'd0;
      k_q       <= 4'd0;
      pend_q    <= 1'b0;
      curAddr_q <= 16'd0;
      refAddr_q <= 16'd0;
    end else begin
      state_q   <= state_d;
      width_q   <= width_d;
      height_q  <= height_d;
      bx_q      <= bx_d;
      by_q      <= by_d;
      candX_q   <= candX_d;
      candY_q   <= candY_d;
      bestX_q   <= bestX_d;
      bestY_q   <= bestY_d;
      bestSad_q <= bestSad_d;
      sad_q     <= sad_d;
      k_q       <= k_d;
      pend_q    <= pend_d;
      curAddr_q <= curAddr_d;
      refAddr_q <= refAddr_d;
    end
  end

  assign cur_addr = curAddr_q;
  assign ref_addr = refAddr_q;
  assign mv_we    = (state_q == WRITE);
  assign mv_index = {8'd0, bx_q} + {8'd0, by_q} * {8'd0, width_q};
  assign mvx      = bestX_q;
  assign mvy      = bestY_q;
  assign busy     = (state_q != IDLE) && (state_q != DONE);
  assign MV_fin   = (state_q == DONE);

endmodule

// File: tb/tb_motion_estimator.sv
// tb_motion_estimator
// Self-checking bench for motion_estimator. Frame memories with one-cycle
// read latency feed the DUT; a full-search reference model computes the
// expected MV for every block, and a scoreboard process checks each write.
module tb_motion_estimator;

  localparam int SR = 2;

  logic              CLK = 1'b0;
  logic              reset;
  logic              start;
  logic [7:0]        width, height;
  logic [15:0]       cur_addr, ref_addr, mv_index;
  logic [7:0]        cur_pix, ref_pix;
  logic              mv_we, busy, MV_fin;
  logic signed [7:0] mvx, mvy;

  logic [7:0] curMem [0:65535];
  logic [7:0] refMem [0:65535];

  typedef struct {
    int idx;
    int mx;
    int my;
  } mvRec_t;

  mvRec_t expQ[$];
  int checks = 0;
  int errors = 0;
  int writeCount = 0;
  int firstWriteCyc = 0;
  int cycleCnt = 0;

  motion_estimator #(.SR(SR), .BS(4)) dut (
    .CLK(CLK), .reset(reset), .start(start), .width(width), .height(height),
    .cur_addr(cur_addr), .cur_pix(cur_pix), .ref_addr(ref_addr), .ref_pix(ref_pix),
    .mv_we(mv_we), .mv_index(mv_index), .mvx(mvx), .mvy(mvy),
    .busy(busy), .MV_fin(MV_fin)
  );

  always #5 CLK = ~CLK;

  // Synchronous-read frame memories.
  always @(posedge CLK) begin
    cur_pix <= curMem[cur_addr];
    ref_pix <= refMem[ref_addr];
  end

  always @(posedge CLK) cycleCnt <= cycleCnt + 1;

  // Scoreboard: every MV write must match the next expected record.
  always @(negedge CLK) begin
    mvRec_t e;
    if (mv_we) begin
      if (writeCount == 0) firstWriteCyc = cycleCnt;
      writeCount++;
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_write: got index=%0d mv=(%0d,%0d), required no write",
                 mv_index, mvx, mvy);
      end else begin
        e = expQ.pop_front();
        if (int'(mv_index) != e.idx || int'(mvx) != e.mx || int'(mvy) != e.my) begin
          errors++;
          $display("[TB] FAIL mv_write: got index=%0d mv=(%0d,%0d), required index=%0d mv=(%0d,%0d)",
                   mv_index, mvx, mvy, e.idx, e.mx, e.my);
        end
      end
    end
  end

  // Named comparison of an observed value against a required one.
  task automatic checkOutput(input string name, input int actual, input int required);
    checks++;
    if (actual != required) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
    end
  endtask

  // Pulse start for one cycle; startCyc is the cycle in which start is high.
  task automatic applyStimulus(input int w, input int h, output int startCyc);
    @(negedge CLK);
    width    = 8'(w);
    height   = 8'(h);
    start    = 1'b1;
    startCyc = cycleCnt;
    @(negedge CLK);
    start = 1'b0;
  endtask

  // Wait (bounded) for MV_fin; finCyc is the first cycle it is seen high.
  task automatic waitDone(output int finCyc);
    int n = 0;
    while (n < 20000 && !MV_fin) begin
      @(negedge CLK);
      n++;
    end
    finCyc = cycleCnt;
    checkOutput("mv_fin_rise", int'(MV_fin), 1);
  endtask

  // Full-search model: first in-frame candidate with strictly lowest SAD.
  task automatic modelBlock(input int w, input int h, input int bx, input int by,
                            output int bmx, output int bmy);
    int best = 8191;
    int row = 4 * w;
    bmx = 0;
    bmy = 0;
    for (int my = -SR; my <= SR; my++) begin
      for (int mx = -SR; mx <= SR; mx++) begin
        int x0 = bx * 4 - mx;
        int y0 = by * 4 - my;
        if (x0 >= 0 && x0 + 3 <= 4 * w - 1 && y0 >= 0 && y0 + 3 <= 4 * h - 1) begin
          int sad = 0;
          for (int dy = 0; dy < 4; dy++) begin
            for (int dx = 0; dx < 4; dx++) begin
              int d = int'(curMem[(bx * 4 + dx) + (by * 4 + dy) * row]) -
                      int'(refMem[(x0 + dx) + (y0 + dy) * row]);
              sad += (d < 0) ? -d : d;
            end
          end
          if (sad < best) begin
            best = sad;
            bmx  = mx;
            bmy  = my;
          end
        end
      end
    end
  endtask

  task automatic buildExpected(input int w, input int h);
    int mx, my;
    expQ.delete();
    for (int by = 0; by < h; by++) begin
      for (int bx = 0; bx < w; bx++) begin
        modelBlock(w, h, bx, by, mx, my);
        expQ.push_back('{bx + by * w, mx, my});
      end
    end
  endtask

  task automatic setupSame(input int w, input int h);
    for (int a = 0; a < 16 * w * h; a++) begin
      curMem[a] = 8'($urandom);
      refMem[a] = curMem[a];
    end
  endtask

  // Current frame is the reference moved 1 pixel right and 2 pixels down.
  task automatic setupShift(input int w, input int h);
    int row = 4 * w;
    for (int a = 0; a < 16 * w * h; a++) refMem[a] = 8'($urandom);
    for (int y = 0; y < 4 * h; y++) begin
      for (int x = 0; x < row; x++) begin
        if (x >= 1 && y >= 2) curMem[x + y * row] = refMem[(x - 1) + (y - 2) * row];
        else curMem[x + y * row] = 8'($urandom);
      end
    end
  endtask

  task automatic setupFlat(input int w, input int h);
    for (int a = 0; a < 16 * w * h; a++) begin
      curMem[a] = 8'h80;
      refMem[a] = 8'h80;
    end
  endtask

  initial begin
    int s, f, dummy, n;
    reset  = 1'b1;
    start  = 1'b0;
    width  = 8'd0;
    height = 8'd0;
    for (int a = 0; a < 65536; a++) begin
      curMem[a] = 8'd0;
      refMem[a] = 8'd0;
    end
    #2;
    checkOutput("reset_mv_we", int'(mv_we), 0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_mv_fin", int'(MV_fin), 0);
    checkOutput("reset_cur_addr", int'(cur_addr), 0);
    checkOutput("reset_ref_addr", int'(ref_addr), 0);
    checkOutput("reset_mv_index", int'(mv_index), 0);
    checkOutput("reset_mvx", int'(mvx), 0);
    checkOutput("reset_mvy", int'(mvy), 0);
    @(negedge CLK);
    @(negedge CLK);
    reset = 1'b0;

    // Single block, identical frames: only (0,0) is in range.
    $display("[TB] 1x1 identical frames");
    setupSame(1, 1);
    buildExpected(1, 1);
    checkOutput("model_1x1_mvx", expQ[0].mx, 0);
    checkOutput("model_1x1_mvy", expQ[0].my, 0);
    writeCount = 0;
    applyStimulus(1, 1, s);
    checkOutput("busy_after_start", int'(busy), 1);
    checkOutput("fin_after_start", int'(MV_fin), 0);
    waitDone(f);
    checkOutput("first_write_cycle", firstWriteCyc - s, 45);
    checkOutput("fin_cycle", f - s, 46);
    checkOutput("writes_1x1", writeCount, 1);
    checkOutput("busy_at_done", int'(busy), 0);
    checkOutput("cur_addr_hold", int'(cur_addr), 15);
    checkOutput("ref_addr_hold", int'(ref_addr), 15);
    checkOutput("queue_empty_1x1", expQ.size(), 0);

    // 4x4 blocks, motion (+1,+2).
    $display("[TB] 4x4 shifted frames");
    setupShift(4, 4);
    buildExpected(4, 4);
    checkOutput("model_shift_b5_mvx", expQ[5].mx, 1);
    checkOutput("model_shift_b5_mvy", expQ[5].my, 2);
    checkOutput("model_shift_b15_mvx", expQ[15].mx, 1);
    checkOutput("model_shift_b15_mvy", expQ[15].my, 2);
    writeCount = 0;
    applyStimulus(4, 4, s);
    waitDone(f);
    checkOutput("writes_shift", writeCount, 16);
    checkOutput("queue_empty_shift", expQ.size(), 0);

    // Flat frames: earliest valid candidate wins every tie.
    $display("[TB] 4x4 flat frames");
    setupFlat(4, 4);
    buildExpected(4, 4);
    checkOutput("model_flat_b0_mvx", expQ[0].mx, -2);
    checkOutput("model_flat_b0_mvy", expQ[0].my, -2);
    checkOutput("model_flat_b3_mvx", expQ[3].mx, 0);
    checkOutput("model_flat_b3_mvy", expQ[3].my, -2);
    checkOutput("model_flat_b12_mvx", expQ[12].mx, -2);
    checkOutput("model_flat_b12_mvy", expQ[12].my, 0);
    checkOutput("model_flat_b15_mvx", expQ[15].mx, 0);
    checkOutput("model_flat_b15_mvy", expQ[15].my, 0);
    writeCount = 0;
    applyStimulus(4, 4, s);
    waitDone(f);
    checkOutput("writes_flat", writeCount, 16);
    checkOutput("queue_empty_flat", expQ.size(), 0);

    // Reset during block 3, then a clean restart.
    $display("[TB] reset mid-frame");
    setupShift(4, 4);
    buildExpected(4, 4);
    writeCount = 0;
    applyStimulus(4, 4, s);
    n = 0;
    while (n < 10000 && writeCount < 3) begin
      @(negedge CLK);
      n++;
    end
    checkOutput("writes_before_reset", writeCount, 3);
    reset = 1'b1;
    #1;
    checkOutput("abort_mv_we", int'(mv_we), 0);
    checkOutput("abort_busy", int'(busy), 0);
    expQ.delete();
    @(negedge CLK);
    @(negedge CLK);
    reset = 1'b0;
    writeCount = 0;
    repeat (600) @(negedge CLK);
    checkOutput("writes_after_abort", writeCount, 0);
    checkOutput("idle_busy", int'(busy), 0);
    checkOutput("idle_mv_fin", int'(MV_fin), 0);
    buildExpected(4, 4);
    applyStimulus(4, 4, s);
    waitDone(f);
    checkOutput("writes_restart", writeCount, 16);
    checkOutput("queue_empty_restart", expQ.size(), 0);

    // A start while busy must be ignored.
    $display("[TB] start while busy");
    setupFlat(4, 4);
    buildExpected(4, 4);
    writeCount = 0;
    applyStimulus(4, 4, s);
    repeat (100) @(negedge CLK);
    checkOutput("busy_mid_frame", int'(busy), 1);
    applyStimulus(1, 1, dummy);
    waitDone(f);
    checkOutput("writes_busy_start", writeCount, 16);
    checkOutput("queue_empty_busy_start", expQ.size(), 0);

    // Zero-sized frames finish with no writes.
    $display("[TB] zero-size frames");
    expQ.delete();
    writeCount = 0;
    applyStimulus(0, 4, s);
    waitDone(f);
    checkOutput("writes_width0", writeCount, 0);
    applyStimulus(3, 0, s);
    waitDone(f);
    checkOutput("writes_height0", writeCount, 0);
    checkOutput("busy_height0", int'(busy), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
